// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg
// Shared types and constants for the USB transmit packet buffer.
//   tx_packet_t   : packet command codes sent to the transmitter
//   txbuf_state_t : handshake FSM states of tx_packet_buffer
//   TX_BUF_DEPTH  : byte capacity of the transmit FIFO
//   START_TIMEOUT : cycles to wait for the transmitter to start before giving up
package usb_tx_pkg;

  localparam int TX_BUF_DEPTH  = 64;
  localparam int START_TIMEOUT = 16;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2,
    NAK  = 2'd3
  } tx_packet_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_BUSY,
    ST_DONE
  } txbuf_state_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// tx_fifo_mem
// Byte storage for the transmit FIFO: DEPTH x 8 array, synchronous write,
// combinational read so the FIFO head is visible in the same cycle
// (first-word fall-through). Storage is not reset; validity is tracked by
// the pointer/count logic in the parent.
// Ports:
//   clk     : system clock, rising edge
//   wr_en   : write wr_data at wr_addr on the next rising edge
//   wr_addr : write address
//   wr_data : write byte
//   rd_addr : read address
//   rd_data : byte stored at rd_addr (combinational)
module tx_fifo_mem
  import usb_tx_pkg::*;
#(
  parameter int DEPTH  = TX_BUF_DEPTH,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tx_packet_buffer.sv
// tx_packet_buffer
// Transmit-side byte FIFO sitting between the AHB slave and the USB
// transmitter. Software fills the FIFO, then requests a packet; the buffer
// issues a one-cycle packet command with a size snapshot, serves bytes on the
// transmitter's get strobe and reports one busy/done handshake per packet.
// Optional feature (macro TX_BUF_UNDERRUN_EN): adds sticky underrun_err, set on
// a pop of an empty FIFO or when a DATA packet finishes with fewer pops than
// its snapshot size; cleared by flush.
// Ports:
//   clk, n_rst          : clock (rising edge) and asynchronous active-low reset
//   store_tx_data       : push tx_data_in this cycle
//   tx_data_in          : byte to push
//   flush               : empty the FIFO (only honoured in IDLE)
//   tx_req, tx_req_type : one-cycle start request with packet type (0 ignored)
//   tx_status           : high while the transmitter is sending
//   get_tx_packet_data  : transmitter pops the head byte
//   tx_packet           : packet command, nonzero for exactly one cycle
//   tx_packet_data      : FIFO head byte, 0 when empty
//   tx_packet_data_size : byte count snapshot of the current packet
//   buffer_occupancy    : current FIFO fill level 0..DEPTH
//   tx_busy             : high from accepted request until done
//   tx_done             : one-cycle completion pulse
//   overflow_err        : sticky, push into a full FIFO; cleared by flush
module tx_packet_buffer
  import usb_tx_pkg::*;
#(
  parameter int DEPTH  = TX_BUF_DEPTH,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          store_tx_data,
  input  logic [7:0]    tx_data_in,
  input  logic          flush,
  input  logic          tx_req,
  input  logic [1:0]    tx_req_type,
  input  logic          tx_status,
  input  logic          get_tx_packet_data,
  output logic [1:0]    tx_packet,
  output logic [7:0]    tx_packet_data,
  output logic [ADDR_W:0] tx_packet_data_size,
  output logic [ADDR_W:0] buffer_occupancy,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          overflow_err
`ifdef TX_BUF_UNDERRUN_EN
  ,
  output logic          underrun_err
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(START_TIMEOUT);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  txbuf_state_t      state_reg, state_next;
  tx_packet_t        type_reg, type_next;
  logic [CNT_W-1:0]  size_reg, size_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;

  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;

  logic              is_idle;
  logic              flush_ok;
  logic              pop_ok;
  logic              push_ok;
  logic              wr_en;
  logic [7:0]        head_byte;

  assign is_idle  = (state_reg == ST_IDLE);
  assign flush_ok = flush && is_idle;
  assign pop_ok   = get_tx_packet_data && (count_reg != '0);
  // A full FIFO still accepts a push when a pop frees the head slot in the
  // same cycle; the write lands on the slot being vacated.
  assign push_ok  = store_tx_data && ((count_reg != FULL) || pop_ok);
  assign wr_en    = push_ok && !flush_ok;

  tx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (tx_data_in),
    .rd_addr (rd_ptr_reg),
    .rd_data (head_byte)
  );

  // FIFO pointers, fill level and overflow flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush_ok) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      count_reg <= count_reg + {{(CNT_W-1){1'b0}}, push_ok}
                             - {{(CNT_W-1){1'b0}}, pop_ok};
      if (store_tx_data && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Handshake FSM: state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
      type_reg  <= NONE;
      size_reg  <= '0;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      type_reg  <= type_next;
      size_reg  <= size_next;
      timer_reg <= timer_next;
    end
  end

  // Handshake FSM: next state
  always_comb begin
    state_next = state_reg;
    type_next  = type_reg;
    size_next  = size_reg;
    timer_next = timer_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (tx_req && (tx_req_type != 2'd0)) begin
          type_next  = tx_packet_t'(tx_req_type);
          // Only bytes already in the FIFO belong to this packet.
          size_next  = (tx_packet_t'(tx_req_type) == DATA) ? count_reg : '0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_next = '0;
        state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (tx_status) begin
          state_next = ST_BUSY;
        end else if (timer_reg == TMR_W'(START_TIMEOUT - 1)) begin
          // Transmitter never started: close the handshake anyway.
          state_next = ST_DONE;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      ST_BUSY: begin
        if (!tx_status) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign tx_packet           = (state_reg == ST_ISSUE) ? type_reg : NONE;
  assign tx_packet_data      = (count_reg != '0) ? head_byte : 8'h00;
  assign tx_packet_data_size = size_reg;
  assign buffer_occupancy    = count_reg;
  assign tx_busy             = !is_idle;
  assign tx_done             = (state_reg == ST_DONE);
  assign overflow_err        = overflow_reg;

`ifdef TX_BUF_UNDERRUN_EN
  logic [CNT_W-1:0] pop_cnt_reg;
  logic             underrun_reg;

  // pop_cnt_reg counts pops served while a packet is in flight; it is held at
  // zero in IDLE so each packet starts fresh. Saturating at FULL is enough
  // because it is only compared against a snapshot of at most DEPTH.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pop_cnt_reg  <= '0;
      underrun_reg <= 1'b0;
    end else begin
      if (is_idle) begin
        pop_cnt_reg <= '0;
      end else if (pop_ok && (pop_cnt_reg != FULL)) begin
        pop_cnt_reg <= pop_cnt_reg + CNT_W'(1);
      end
      if (flush_ok) begin
        underrun_reg <= 1'b0;
      end else if ((get_tx_packet_data && (count_reg == '0)) ||
                   ((state_reg == ST_DONE) && (type_reg == DATA) &&
                    (pop_cnt_reg < size_reg))) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  assign underrun_err = underrun_reg;
`endif

endmodule

// File: tb/tb_tx_packet_buffer.sv
// tb_tx_packet_buffer
// Randomised bench for tx_packet_buffer. A queue-based reference model tracks
// FIFO contents and sticky flags; packet commands and completion pulses are
// predicted arithmetically when a request is issued and pushed into scoreboard
// queues that a negedge monitor drains as the DUT presents them.
// Optional feature: define TX_BUF_UNDERRUN_EN to connect and check underrun_err.
module tb_tx_packet_buffer;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       store_tx_data = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       flush = 1'b0;
  logic       tx_req = 1'b0;
  logic [1:0] tx_req_type = 2'd0;
  logic       tx_status = 1'b0;
  logic       get_tx_packet_data = 1'b0;

  logic [1:0] tx_packet;
  logic [7:0] tx_packet_data;
  logic [6:0] tx_packet_data_size;
  logic [6:0] buffer_occupancy;
  logic       tx_busy;
  logic       tx_done;
  logic       overflow_err;
`ifdef TX_BUF_UNDERRUN_EN
  logic       underrun_err;
`endif

  tx_packet_buffer dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .store_tx_data       (store_tx_data),
    .tx_data_in          (tx_data_in),
    .flush               (flush),
    .tx_req              (tx_req),
    .tx_req_type         (tx_req_type),
    .tx_status           (tx_status),
    .get_tx_packet_data  (get_tx_packet_data),
    .tx_packet           (tx_packet),
    .tx_packet_data      (tx_packet_data),
    .tx_packet_data_size (tx_packet_data_size),
    .buffer_occupancy    (buffer_occupancy),
    .tx_busy             (tx_busy),
    .tx_done             (tx_done),
    .overflow_err        (overflow_err)
`ifdef TX_BUF_UNDERRUN_EN
    ,
    .underrun_err        (underrun_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  logic [7:0] ref_q[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  int         m_size = 0;
  bit         m_idle;
  bit         m_pop;
  // Current packet window [pkt_start, pkt_end] (empty when start > end)
  int         pkt_start = 1;
  int         pkt_end   = 0;
  int         pkt_type  = 0;
  int         pkt_size  = 0;
  int         pkt_pops  = 0;

  typedef struct {
    int t;
    int size;
    int at;
  } pkt_exp_t;
  pkt_exp_t exp_pkt_q[$];
  int       exp_done_q[$];

  function automatic bit busy_at(input int c);
    return (c >= pkt_start) && (c <= pkt_end);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applies the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (n_rst) begin
      m_idle = !busy_at(cyc);
      m_pop  = get_tx_packet_data && (ref_q.size() > 0);
      if (tx_req && m_idle && (tx_req_type != 2'd0))
        m_size = (tx_req_type == 2'd1) ? ref_q.size() : 0;
      if (flush && m_idle) begin
        ref_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (get_tx_packet_data && (ref_q.size() == 0)) m_unf = 1'b1;
        if ((cyc == pkt_end) && (pkt_type == 1) && (pkt_pops < pkt_size)) m_unf = 1'b1;
        if (m_pop) begin
          void'(ref_q.pop_front());
          if ((cyc >= pkt_start) && (cyc < pkt_end)) pkt_pops++;
        end
        if (store_tx_data) begin
          if (ref_q.size() < 64) ref_q.push_back(tx_data_in);
          else m_ovf = 1'b1;
        end
      end
    end
    cyc++;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (n_rst) begin
      check("occupancy", buffer_occupancy, ref_q.size());
      check("overflow_err", overflow_err, m_ovf);
      check("tx_busy", tx_busy, busy_at(cyc));
      check("data_size", tx_packet_data_size, m_size);
      check("head_byte", tx_packet_data, (ref_q.size() > 0) ? ref_q[0] : 0);
`ifdef TX_BUF_UNDERRUN_EN
      check("underrun_err", underrun_err, m_unf);
`endif
      while (exp_pkt_q.size() > 0 && exp_pkt_q[0].at < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL tx_packet_missing: got none expected type %0d at cycle %0d",
                 exp_pkt_q[0].t, exp_pkt_q[0].at);
        void'(exp_pkt_q.pop_front());
      end
      if (tx_packet != 2'd0) begin
        if (exp_pkt_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_packet_unexpected: got %0d expected 0 (cycle %0d)", tx_packet, cyc);
        end else begin
          pkt_exp_t e;
          e = exp_pkt_q.pop_front();
          check("tx_packet_type", tx_packet, e.t);
          check("tx_packet_cycle", cyc, e.at);
          check("tx_packet_size", tx_packet_data_size, e.size);
          $display("[TB] packet cmd type=%0d size=%0d cycle=%0d", tx_packet, tx_packet_data_size, cyc);
        end
      end
      while (exp_done_q.size() > 0 && exp_done_q[0] < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL tx_done_missing: got none expected at cycle %0d", exp_done_q[0]);
        void'(exp_done_q.pop_front());
      end
      if (tx_done) begin
        if (exp_done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          check("tx_done_cycle", cyc, exp_done_q.pop_front());
          $display("[TB] packet done cycle=%0d", cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    store_tx_data      = 1'b0;
    get_tx_packet_data = 1'b0;
    flush              = 1'b0;
    tx_req             = 1'b0;
    tx_req_type        = 2'd0;
    tx_status          = 1'b0;
  endtask

  task automatic push_bytes(input int k, input logic [7:0] base, input bit incr);
    for (int i = 0; i < k; i++) begin
      store_tx_data = 1'b1;
      tx_data_in    = incr ? (base + 8'(i)) : 8'($urandom);
      tick();
    end
    store_tx_data = 1'b0;
  endtask

  task automatic pop_bytes(input int k);
    for (int i = 0; i < k; i++) begin
      get_tx_packet_data = 1'b1;
      tick();
    end
    get_tx_packet_data = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset_mid();
    n_rst = 1'b0;
    #1;
    check("rst_tx_packet", tx_packet, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_occupancy", buffer_occupancy, 0);
    check("rst_size", tx_packet_data_size, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_head", tx_packet_data, 0);
    ref_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_size = 0;
    pkt_start = 1; pkt_end = 0; pkt_type = 0;
    exp_pkt_q.delete();
    exp_done_q.delete();
    idle_inputs();
    tick();
    tick();
    n_rst = 1'b1;
    $display("[TB] reset mid-packet released cycle=%0d", cyc);
    tick();
  endtask

  // Issues one packet and plays the transmitter. dly<0 means the transmitter
  // never starts; otherwise tx_status rises dly cycles into WAIT_START and
  // stays high for len cycles.
  task automatic do_packet(input int t, input int dly, input int len, input int npops,
                           input int rst_at, input bit noise);
    int n, s, done, popped;
    pkt_exp_t e;
    n    = cyc;
    s    = n + 2 + dly;
    done = (dly < 0) ? n + 18 : s + len + 1;
    pkt_start = n + 1;
    pkt_end   = done;
    pkt_type  = t;
    pkt_size  = (t == 1) ? ref_q.size() : 0;
    pkt_pops  = 0;
    e.t = t; e.size = pkt_size; e.at = n + 1;
    exp_pkt_q.push_back(e);
    exp_done_q.push_back(done);
    idle_inputs();
    tx_req      = 1'b1;
    tx_req_type = 2'(t);
    tick();
    popped = 0;
    while (cyc <= done) begin
      if ((rst_at >= 0) && (cyc == n + rst_at)) begin
        do_reset_mid();
        return;
      end
      tx_req        = noise && ($urandom_range(0, 9) == 0);
      tx_req_type   = 2'($urandom_range(1, 3));
      flush         = noise && ($urandom_range(0, 9) == 0);
      store_tx_data = noise && ($urandom_range(0, 3) == 0);
      tx_data_in    = 8'($urandom);
      tx_status     = (dly >= 0) && (cyc >= s) && (cyc < s + len);
      get_tx_packet_data = tx_status && (popped < npops);
      if (get_tx_packet_data) popped++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_occupancy", buffer_occupancy, 0);
    check("reset_tx_packet", tx_packet, 0);
    check("reset_tx_busy", tx_busy, 0);
    check("reset_overflow", overflow_err, 0);
    n_rst = 1'b1;
    tick();

    // Five-byte DATA packet served in order
    push_bytes(5, 8'hA0, 1'b1);
    do_packet(1, 1, 40, 5, -1, 1'b0);
    repeat (2) tick();

    // Overflow and flush
    push_bytes(64, 8'h00, 1'b0);
    push_bytes(1, 8'hFF, 1'b1);
    repeat (2) tick();
    pop_bytes(3);
    do_flush();
    tick();

    // Full FIFO with simultaneous push and pop
    push_bytes(64, 8'h10, 1'b1);
    store_tx_data = 1'b1; get_tx_packet_data = 1'b1; tx_data_in = 8'h5A;
    tick();
    idle_inputs();
    tick();
    pop_bytes(64);
    tick();

    // ACK with transmitter never starting: timeout path
    do_packet(2, -1, 0, 0, -1, 1'b0);
    tick();

    // Reset while BUSY with 10 bytes queued
    do_flush();
    push_bytes(10, 8'h30, 1'b1);
    do_packet(1, 2, 30, 0, 8, 1'b0);

    // Random traffic
    for (int it = 0; it < 25; it++) begin
      int k, r;
      k = $urandom_range(1, 20);
      for (int j = 0; j < k; j++) begin
        store_tx_data      = ($urandom_range(0, 1) == 0);
        tx_data_in         = 8'($urandom);
        get_tx_packet_data = ($urandom_range(0, 2) == 0);
        flush              = ($urandom_range(0, 19) == 0);
        tick();
      end
      idle_inputs();
      r = $urandom_range(0, 16);
      do_packet($urandom_range(1, 3), (r == 16) ? -1 : r, $urandom_range(1, 20),
                $urandom_range(0, 8), -1, 1'b1);
    end

    repeat (25) tick();
    check("pkt_queue_drained", exp_pkt_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_packet_buffer.md
Name: tx_packet_buffer

Overview:
- Upstream neighbour of the USB transmitter.
- Holds up to 64 outgoing data bytes written by the AHB-side slave.
- Issues a one-cycle packet command with size to the transmitter and serves bytes on its get-data strobe.
- Tracks transmitter activity so software sees one busy/done handshake per packet.

Parameters:
- DEPTH, 64, byte capacity (power of two)
- ADDR_W, 6, log2(DEPTH); count width is ADDR_W+1

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- store_tx_data  input  1  push tx_data_in into FIFO this cycle
- tx_data_in  input  8  byte to push
- flush  input  1  clear FIFO contents (accepted only in IDLE)
- tx_req  input  1  start request, one-cycle pulse
- tx_req_type  input  2  packet type with tx_req: 1 DATA, 2 ACK, 3 NAK; 0 ignored
- tx_status  input  1  high while transmitter is sending
- get_tx_packet_data  input  1  transmitter pops head byte
- tx_packet  output  2  packet command to transmitter, nonzero for exactly one cycle
- tx_packet_data  output  8  FIFO head byte (first-word fall-through)
- tx_packet_data_size  output  7  byte count snapshot for current packet
- buffer_occupancy  output  7  current FIFO count, 0..64
- tx_busy  output  1  high from accepted tx_req until done
- tx_done  output  1  one-cycle pulse when transmitter finishes
- overflow_err  output  1  sticky: push while full; cleared by flush

Behaviour:
- Reset (async, n_rst low): pointers 0, count 0, all outputs 0, FSM IDLE.
- FIFO:
  - tx_packet_data = mem[rd_ptr] when count>0, else 8'h00.
  - Pointers wrap modulo DEPTH.
  - Push when count<64: write at wr_ptr, then wr_ptr++ and count++.
  - Push when count==64: data dropped, overflow_err set.
  - Pop when count>0: rd_ptr++, count--.
  - Pop when empty: ignored.
  - Push and pop in the same cycle:
    - count 1..63: both occur, count unchanged.
    - count 0: push only.
    - count 64: both occur, no overflow.
  - Flush in IDLE: pointers and count to 0, overflow_err cleared; overrides push/pop that cycle.
  - Flush outside IDLE: ignored.
- FSM states:
  - IDLE: on tx_req with tx_req_type!=0, latch type and size (size = buffer_occupancy if type==DATA, else 0); go to ISSUE.
  - ISSUE: drive tx_packet = latched type for one cycle; go to WAIT_START.
  - WAIT_START: wait for tx_status==1, then go to BUSY. If no start within 16 cycles, go to DONE.
  - BUSY: wait for tx_status==0, then go to DONE.
  - DONE: assert tx_done one cycle; go to IDLE.
- tx_busy = 1 in every state except IDLE.
- tx_req outside IDLE: ignored.
- Latency: tx_req at cycle N gives tx_packet at N+1 and tx_busy high from N+1.
- tx_packet_data_size holds its value until the next accepted tx_req.
- Pushes during BUSY are allowed but are not counted in the in-flight packet size.
- Reset mid-packet: immediate return to IDLE, FIFO emptied.

Optional Feature:
- Macro: TX_BUF_UNDERRUN_EN.
- Defined:
  - Adds output underrun_err (1 bit, sticky).
  - Set when get_tx_packet_data is asserted while count==0; cleared by flush.
  - Also set if DATA packet completes (DONE) while pops < snapshot size.
- Undefined: port absent, both conditions silently ignored.

Decomposition:
- Package usb_tx_pkg:
  - tx_packet_t enum (NONE=0, DATA=1, ACK=2, NAK=3)
  - txbuf_state_t enum
  - TX_BUF_DEPTH=64
  - START_TIMEOUT=16
- Sub-module tx_fifo_mem:
  - DEPTH x 8 register array
  - synchronous write, combinational read by address
  - no reset on storage
- Pointer, count and FSM logic live in tx_packet_buffer.

Test Plan:
- Push 0xA0..0xA4 (5 bytes); tx_req DATA; tx_status high 3 cycles later for 40 cycles with 5 pops -> tx_packet=1 one cycle, size=5, bytes A0..A4 in order, tx_done one cycle after tx_status falls, occupancy 0.
- Push 64 bytes then a 65th (0xFF) -> occupancy 64, overflow_err=1, byte 0xFF never read; flush -> occupancy 0, overflow_err=0.
- Full FIFO with push and pop in the same cycle -> occupancy stays 64, no overflow_err, popped byte is oldest.
- tx_req ACK, tx_status held 0 -> tx_busy for 1+16 cycles, then tx_done, size=0.
- Assert n_rst low during BUSY with occupancy 10 -> all outputs 0 immediately; after release, FSM IDLE and occupancy 0.
- With TX_BUF_UNDERRUN_EN: pop on empty -> underrun_err=1; DATA size 4 with only 3 pops -> underrun_err set at DONE.
